// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   Instruction memory for the five-stage core with a byte-serial load port.
//   The CPU is held in reset while a program image is streamed in. Bytes are
//   packed big-endian into 32-bit words, which are written sequentially from
//   word 0. Once the requested number of words is in, the CPU gets two more
//   reset cycles and is then released. Instruction reads are combinational.
//
// Optional feature: define LOADER_TIMEOUT_EN to abort a load (err_o=1, back
//   to IDLE) when no byte arrives for TIMEOUT_CYC consecutive LOAD cycles.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   ld_start_i        one-cycle pulse, starts a load and samples ld_len_i
//   ld_len_i          number of words to load (1 .. 2^ADDR_LOG2)
//   ld_valid_i/ld_byte_i/ld_ready_o   byte load handshake
//   cpu_rst_o         active-high reset to the CPU (low only in RUN)
//   busy_o            loading or releasing
//   load_done_o       image loaded, CPU running
//   err_o             sticky error (bad length / timeout), cleared by a start
//   rom_ce_i/rom_addr_i/rom_data_o    CPU instruction fetch port
module inst_rom_loader #(
  parameter int ADDR_LOG2   = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_start_i,
  input  logic [ADDR_LOG2:0]   ld_len_i,
  input  logic                 ld_valid_i,
  input  logic [7:0]           ld_byte_i,
  output logic                 ld_ready_o,
  output logic                 cpu_rst_o,
  output logic                 busy_o,
  output logic                 load_done_o,
  output logic                 err_o,
  input  logic                 rom_ce_i,
  input  logic [31:0]          rom_addr_i,
  output logic [31:0]          rom_data_o
);

  localparam int DEPTH = 1 << ADDR_LOG2;
  // Length/count are one bit wider than the word index so a full-depth load
  // can be expressed and counted without wrapping.
  localparam logic [ADDR_LOG2:0] MAX_LEN = (ADDR_LOG2+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic [1:0]           state;
  logic [ADDR_LOG2:0]   len_q;
  logic [ADDR_LOG2:0]   count;
  logic [ADDR_LOG2:0]   count_nxt;
  logic [1:0]           byte_idx;
  logic [23:0]          asm_q;     // first three bytes of the word in flight
  logic                 rel_cnt;
  logic                 err_q;
  logic                 len_ok;
  logic                 byte_fire;
  logic                 word_fire;
  logic [31:0]          word_nxt;

  logic [31:0] mem [DEPTH];

  assign len_ok    = (ld_len_i != '0) && (ld_len_i <= MAX_LEN);
  // A start pulse wins over a byte presented in the same cycle.
  assign byte_fire = (state == S_LOAD) && ld_valid_i && !ld_start_i;
  assign word_fire = byte_fire && (byte_idx == 2'd3);
  assign word_nxt  = {asm_q, ld_byte_i};
  assign count_nxt = count + 1'b1;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] gap_cnt;
  logic        gap_hit;
  assign gap_hit = (gap_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic timeout_param_unused;
  assign timeout_param_unused = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      count    <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      rel_cnt  <= 1'b0;
      err_q    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      gap_cnt  <= '0;
`endif
    end else if (ld_start_i) begin
      err_q    <= !len_ok;
      count    <= '0;
      byte_idx <= '0;
      len_q    <= ld_len_i;
      rel_cnt  <= 1'b0;
      state    <= len_ok ? S_LOAD : S_IDLE;
`ifdef LOADER_TIMEOUT_EN
      gap_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (byte_fire) begin
            byte_idx <= byte_idx + 2'd1;   // wraps to 0 after the 4th byte
            asm_q    <= {asm_q[15:0], ld_byte_i};
`ifdef LOADER_TIMEOUT_EN
            gap_cnt  <= '0;
`endif
            if (word_fire) begin
              count <= count_nxt;
              if (count_nxt == len_q) begin
                state   <= S_REL;
                rel_cnt <= 1'b0;
              end
            end
          end
`ifdef LOADER_TIMEOUT_EN
          else if (gap_hit) begin
            err_q    <= 1'b1;
            state    <= S_IDLE;
            byte_idx <= '0;          // partial word is dropped
            gap_cnt  <= '0;
          end else begin
            gap_cnt  <= gap_cnt + 32'd1;
          end
`endif
        end
        // Two full cycles in RELEASE before the CPU leaves reset.
        S_REL: begin
          if (rel_cnt) state   <= S_RUN;
          else         rel_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Array is not reset; unwritten words read back undefined.
  always_ff @(posedge clk) begin
    if (word_fire) mem[count[ADDR_LOG2-1:0]] <= word_nxt;
  end

  assign ld_ready_o  = (state == S_LOAD);
  assign busy_o      = (state == S_LOAD) || (state == S_REL);
  assign load_done_o = (state == S_RUN);
  assign cpu_rst_o   = (state != S_RUN);
  assign err_o       = err_q;

  // Read path: byte address, low two bits ignored, anything above the array
  // reads as zero. A same-cycle write only lands at the edge, so a colliding
  // read sees the old word.
  logic [ADDR_LOG2-1:0]  rd_idx;
  logic                  addr_hi;
  logic                  addr_lsb_unused;

  assign rd_idx          = rom_addr_i[ADDR_LOG2+1:2];
  assign addr_hi         = |rom_addr_i[31:ADDR_LOG2+2];
  assign addr_lsb_unused = ^rom_addr_i[1:0];
  assign rom_data_o      = (rom_ce_i && !addr_hi) ? mem[rd_idx] : 32'd0;

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction memory for the five-stage core with a byte-serial load port. It sits directly downstream of the CPU's instruction-fetch port (`rom_ce_o` / `rom_addr_o` → `rom_data_i`) and serves combinational reads. It holds the CPU in reset while a program image is streamed in, assembles bytes into 32-bit words, writes them sequentially from word 0, and releases the CPU once the requested length has been loaded.

## Interface
Parameters:
- `ADDR_LOG2`, 10, log2 of memory depth in 32-bit words.
- `TIMEOUT_CYC`, 65535, maximum idle gap between bytes while loading; used only with `LOADER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_start_i`  in  1  one-cycle pulse; begins a new load and samples `ld_len_i`.
- `ld_len_i`  in  ADDR_LOG2+1  number of words to load.
- `ld_valid_i`  in  1  a load byte is presented.
- `ld_byte_i`  in  8  load byte.
- `ld_ready_o`  out  1  a load byte is accepted this cycle when `ld_valid_i` is also high.
- `cpu_rst_o`  out  1  active-high reset to the CPU.
- `busy_o`  out  1  high in LOAD and RELEASE.
- `load_done_o`  out  1  high in RUN.
- `err_o`  out  1  sticky error flag; cleared by the next `ld_start_i`.
- `rom_ce_i`  in  1  fetch enable from the CPU.
- `rom_addr_i`  in  32  byte address from the CPU.
- `rom_data_o`  out  32  instruction word.

## Operation
- FSM states:
  - **IDLE**: entered from reset.
  - **LOAD**
  - **RELEASE**: 2 cycles.
  - **RUN**
- Reset values: state IDLE, `cpu_rst_o`=1, `ld_ready_o`=0, `busy_o`=0, `load_done_o`=0, `err_o`=0, word count 0, byte index 0. The memory array is not reset; unwritten words read as undefined.
- `ld_start_i` in any state:
  - Clears `err_o`, the word count and the byte index, and latches the length.
  - If `ld_len_i`=0 or `ld_len_i` > 2^ADDR_LOG2: `err_o` is set and the state goes to IDLE.
  - Otherwise the state goes to LOAD.
  - `cpu_rst_o` is high from the following edge onward.
  - `ld_start_i` during LOAD aborts the current load and restarts it. Words already written are retained.
- LOAD:
  - `ld_ready_o`=1.
  - Each accepted byte shifts into a big-endian assembly register: the first byte lands in bits 31:24.
  - On the 4th byte, the word is written to `mem[count]`, `count` increments, and the byte index wraps to 0.
  - When the write makes `count` equal the latched length, the state goes to RELEASE.
- RELEASE: `ld_ready_o`=0, `cpu_rst_o`=1. After 2 cycles the state goes to RUN.
- RUN: `cpu_rst_o`=0, `load_done_o`=1. Load bytes are ignored.
- Read path (combinational):
  - `rom_ce_i`=0 gives `rom_data_o`=0.
  - Otherwise the word index is `rom_addr_i[ADDR_LOG2+1:2]`; `rom_addr_i[1:0]` is ignored.
  - Any nonzero address bit above ADDR_LOG2+1 gives `rom_data_o`=0.
- Write/read collision on the same word in the same cycle: the read returns the old contents.

## Timing
- Byte acceptance: zero-latency handshake. `ld_valid_i & ld_ready_o` at an edge consumes the byte.
- Word write latency: the word completed at edge E is readable on `rom_data_o` after E (same cycle, combinationally).
- Release:
  - Final word written at edge E: RELEASE from E.
  - At E+2: RUN, `cpu_rst_o` falls, `load_done_o` rises.
  - The CPU therefore sees at least 2 full reset cycles after the last write.
- `ld_start_i` sampled at edge S: `busy_o` and `cpu_rst_o`=1 from S (or IDLE with `err_o`=1 from S if the length is invalid); `ld_ready_o`=1 from S.
- Asynchronous reset mid-load: all registers take reset values immediately; the partially assembled word is discarded.
- Exactly 2^ADDR_LOG2 words is a valid length; `count` must not overflow.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A gap counter runs in LOAD and resets on every accepted byte and on `ld_start_i`.
  - If it reaches `TIMEOUT_CYC`: `err_o`=1, state goes to IDLE, `cpu_rst_o` stays 1, the partial word is discarded.
- `LOADER_TIMEOUT_EN` undefined: no gap counter. LOAD waits indefinitely for bytes.

## Test plan
- Reset, then `ld_start_i` with len=2, bytes 0x20,0x01,0x00,0x05,0x34,0x02,0x00,0x0A → mem[0]=0x20010005, mem[1]=0x3402000A. `cpu_rst_o` falls exactly 2 cycles after the 8th byte's edge; `load_done_o`=1.
- After load, `rom_ce_i`=1 with `rom_addr_i`=0x4 → 0x3402000A; with 0x6 → 0x3402000A; with 0x00001000 (ADDR_LOG2=10) → 0; with `rom_ce_i`=0 → 0.
- `ld_start_i` with len=0, and with len=1025 → `err_o`=1, state IDLE, `cpu_rst_o`=1, `ld_ready_o`=0. A following valid start clears `err_o`.
- `ld_start_i` asserted after 6 bytes of a len=3 load → restart: next 4 bytes land in mem[0]; completion requires 12 further bytes.
- `rst` low during LOAD after 3 bytes → outputs at reset values immediately; the next load writes mem[0] from a fresh byte index.
- With `LOADER_TIMEOUT_EN`, `TIMEOUT_CYC`=16: stall 16 cycles mid-word → `err_o`=1, IDLE, `cpu_rst_o`=1. A 15-cycle gap completes the load normally.
